mul_csv_seq: RTL and testbench
==============================

Name: mul_csv_seq

Overview:
- Sequential, digit-serial successor to the combinational carry-save multiplier.
- Accepts a multiplier in carry-save form (XS, XC) and a multiplicand Y, and produces the product in carry-save form (PS, PC) after N = ceil(widthX/digitW) cycles.
- Adds three things the combinational block lacks: signed/unsigned mode per transaction, optional carry-save accumulate onto the previous result, and valid/ready handshakes on input and output.
- Sits in datapaths that trade latency for area: MAC loops, iterative filters.

Parameters:
- widthX, 8, word width of XS, XC; must be <= widthY.
- widthY, 8, word width of Y.
- digitW, 2, multiplier bits consumed per cycle; 1 <= digitW <= widthX.
- speed, lau_pkg::FAST, performance parameter passed to the internal compressor.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- InValid  in  1  operand transfer request.
- InReady  out  1  block can accept operands.
- XS  in  widthX  multiplier, sum part.
- XC  in  widthX  multiplier, carry part.
- Y  in  widthY  multiplicand.
- Tc  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- Acc  in  1  1 = add the product onto the previous result; sampled at accept.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- PS  out  widthX+widthY  product, sum part.
- PC  out  widthX+widthY  product, carry part.

Behaviour:
- Definitions: W = widthX+widthY; N = ceil(widthX/digitW); all arithmetic is mod 2^W.
- Reset (async, RST=1):
  - state IDLE, digit counter 0.
  - PS=PC=0, OutValid=0, InReady=0 while RST is high.
  - InReady=1 in the first cycle after RST deasserts.
- States IDLE, BUSY, DONE:
  - InReady = (state==IDLE) | (state==DONE & OutReady). This is combinational from OutReady.
  - Accept occurs when InValid & InReady. On accept:
    - X = (XS+XC) mod 2^widthX, resolved by a carry-propagate add and registered.
    - X is extended to N*digitW bits: sign-extended if Tc, else zero-extended.
    - Y is sign- or zero-extended to W bits in the same way.
    - Tc is latched.
    - Accumulator initialised to (PS,PC) if Acc=1, else (0,0).
    - Go to BUSY with counter=0.
  - BUSY, cycle i (0..N-1):
    - Take digit d_i = X[i*digitW +: digitW]. It is unsigned, except that the top digit is signed when Tc=1.
    - Compress the accumulator S, C and digitW shifted rows of d_i*Y<<(i*digitW) into a new S, C.
    - The signed top digit's MSB row is added as its bitwise inverse plus one injected LSB.
    - At i==N-1 go to DONE and drive the result onto PS/PC.
  - DONE: OutValid=1; PS/PC held stable until OutValid & OutReady.
    - Handshake with no new accept: go to IDLE.
    - Handshake with a simultaneous accept: go straight to BUSY (back-to-back).
- Latency: accept at edge t gives OutValid=1 after edge t+N. Throughput is one result per N cycles with OutReady held at 1.
- Result guarantee:
  - PS+PC ≡ X*Y (+ previous PS+PC if Acc) mod 2^W.
  - Unsigned: X*Y uses unsigned operands. Tc: X*Y uses two's-complement operands.
  - The individual PS/PC bit split is implementation-defined.
- Overflow of XS+XC beyond widthX bits wraps silently; the result uses the wrapped X.
- Acc with no prior result since reset accumulates onto 0.
- Acc uses the currently held PS/PC, including the one being popped in the same cycle.
- PS/PC keep the last result in IDLE and BUSY. They update only on entry to DONE or on reset.
- InValid while InReady=0 is ignored; the source must hold it.
- Inputs are sampled only at accept; later changes have no effect.

Decomposition:
- lau_pkg: reuse speed_e; add function num_digits(widthX, digitW) returning the ceiling division.
- One sub-module, mul_csv_seq_digit (combinational):
  - Inputs: digit, Y, position, signed-top flag.
  - Output: digitW+1 aligned rows of W bits, with the correction row holding the +1.
- The existing AddMopCsv(W, digitW+3, speed) compresses these rows together with S and C.
- Assertions:
  - digitW range.
  - widthX <= widthY.
  - PS/PC stable while OutValid & !OutReady.

Test Plan:
- widthX=widthY=8, digitW=2, unsigned: XS=0x0F, XC=0x05, Y=13 -> OutValid exactly 4 cycles after accept, (PS+PC) mod 2^16 = 260.
- Tc=1: XS=0xFC, XC=0x02 (X=-2), Y=0x03 -> PS+PC = 0xFFFA; Tc=1, X=0x80, Y=0x80 -> 0x4000.
- Acc: 10*10 with Acc=0 -> 100; then 3*4 with Acc=1, issued in the same cycle as the first result is popped -> 112; no bubble between them.
- Backpressure: OutReady=0 for 5 cycles -> PS/PC unchanged, InReady=0, new InValid not taken; then OutReady=InValid=1 -> pop and accept on the same edge.
- RST pulsed at BUSY cycle 2 -> OutValid=0 and PS=PC=0 immediately; InReady=1 after release; then Acc=1 with 2*3 -> 6.
- digitW=3, widthX=widthY=8 (N=3): 255*255 -> 65025 after 3 cycles; XS=0xFF, XC=0x02 (wraps to X=1), Y=5 -> 5.

Source files
------------

// File: rtl/lau_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lau_pkg
// Brief    : Shared types and helpers for the arithmetic unit library.
// Revision : 1.0 - initial release
// ============================================================================
package lau_pkg;

  typedef enum logic [0:0] {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  // Number of digitW-bit digits needed to cover width_x bits.
  function automatic int num_digits(input int width_x, input int digit_w);
    return (width_x + digit_w - 1) / digit_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/AddMopCsv.sv
`default_nettype none
// ============================================================================
// Module   : AddMopCsv
// Brief    : Multi-operand carry-save compressor, DEPTH rows down to (S, C).
// Revision : 1.0 - initial release
// ============================================================================
module AddMopCsv
  import lau_pkg::*;
#(
  parameter int     WIDTH = 16,
  parameter int     DEPTH = 5,
  parameter speed_e SPEED = FAST
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] i_rows,
  output logic [WIDTH-1:0]            o_s,
  output logic [WIDTH-1:0]            o_c
);

  function automatic logic [WIDTH-1:0] csa_c(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  generate
    if (SPEED == FAST && DEPTH >= 4) begin : g_split
      // Two half-depth chains in parallel, merged by a final 4:2 stage.
      localparam int c_H = DEPTH / 2;
      logic [WIDTH-1:0] w_sa, w_ca, w_sb, w_cb, w_t, w_u, w_tmp;

      always_comb begin
        w_tmp = '0;
        w_sa  = i_rows[0];
        w_ca  = i_rows[1];
        for (int k = 2; k < c_H; k++) begin
          w_tmp = w_sa ^ w_ca ^ i_rows[k];
          w_ca  = csa_c(w_sa, w_ca, i_rows[k]);
          w_sa  = w_tmp;
        end
        w_sb = i_rows[c_H];
        w_cb = i_rows[c_H+1];
        for (int k = c_H + 2; k < DEPTH; k++) begin
          w_tmp = w_sb ^ w_cb ^ i_rows[k];
          w_cb  = csa_c(w_sb, w_cb, i_rows[k]);
          w_sb  = w_tmp;
        end
        w_t = w_sa ^ w_ca ^ w_sb;
        w_u = csa_c(w_sa, w_ca, w_sb);
        o_s = w_t ^ w_u ^ w_cb;
        o_c = csa_c(w_t, w_u, w_cb);
      end
    end else begin : g_chain
      logic [WIDTH-1:0] w_tmp;

      always_comb begin
        w_tmp = '0;
        o_s   = i_rows[0];
        o_c   = i_rows[1];
        for (int k = 2; k < DEPTH; k++) begin
          w_tmp = o_s ^ o_c ^ i_rows[k];
          o_c   = csa_c(o_s, o_c, i_rows[k]);
          o_s   = w_tmp;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mul_csv_seq_digit.sv
`default_nettype none
// ============================================================================
// Module   : mul_csv_seq_digit
// Brief    : Partial-product rows for one multiplier digit, aligned to i_pos.
// Revision : 1.0 - initial release
// ============================================================================
module mul_csv_seq_digit #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 2,
  parameter int POS_W   = 5
) (
  input  logic [DIGIT_W-1:0]          i_digit,
  input  logic [WIDTH-1:0]            i_y,
  input  logic [POS_W-1:0]            i_pos,
  input  logic                        i_signed_top,
  output logic [DIGIT_W:0][WIDTH-1:0] o_rows
);

  logic [WIDTH-1:0] w_row;

  always_comb begin
    o_rows = '0;
    w_row  = '0;
    for (int j = 0; j < DIGIT_W; j++) begin
      w_row = i_y << (int'(i_pos) + j);
      // The signed top digit's MSB has negative weight: -a = ~a + 1.
      if (i_digit[j])
        o_rows[j] = (i_signed_top && (j == DIGIT_W - 1)) ? ~w_row : w_row;
    end
    o_rows[DIGIT_W] = WIDTH'(i_signed_top & i_digit[DIGIT_W-1]);
  end

endmodule
`default_nettype wire

// File: rtl/mul_csv_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_csv_seq
// Brief    : Digit-serial carry-save multiplier with accumulate and handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module mul_csv_seq
  import lau_pkg::*;
#(
  parameter int     widthX = 8,
  parameter int     widthY = 8,
  parameter int     digitW = 2,
  parameter speed_e speed  = FAST
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [widthX-1:0]        XS,
  input  logic [widthX-1:0]        XC,
  input  logic [widthY-1:0]        Y,
  input  logic                     Tc,
  input  logic                     Acc,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [widthX+widthY-1:0] PS,
  output logic [widthX+widthY-1:0] PC
);

  localparam int c_W  = widthX + widthY;
  localparam int c_N  = num_digits(widthX, digitW);
  localparam int c_XE = c_N * digitW;
  localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_PW = $clog2(c_W) + 1;

  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]              r_state, w_next;
  logic [c_CW-1:0]         r_cnt;
  logic [c_XE-1:0]         r_x;
  logic [c_W-1:0]          r_y, r_s, r_c, r_ps, r_pc;
  logic                    r_tc;

  logic                    w_accept, w_last, w_signed_top;
  logic [widthX-1:0]       w_xsum;
  logic [c_PW-1:0]         w_pos;
  logic [digitW-1:0]       w_digit;
  logic [digitW:0][c_W-1:0] w_rows;
  logic [c_W-1:0]          w_s, w_c;

  assign w_xsum       = XS + XC;
  assign w_accept     = InValid & InReady;
  assign w_last       = (r_cnt == c_LAST);
  assign w_pos        = c_PW'(r_cnt) * c_PW'(digitW);
  assign w_digit      = digitW'(r_x >> w_pos);
  assign w_signed_top = r_tc & w_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next = c_BUSY;
      c_BUSY:  if (w_last)   w_next = c_DONE;
      c_DONE:  if (OutReady) w_next = w_accept ? c_BUSY : c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // InReady is a combinational path from OutReady so a pop and an accept
  // can share one edge.
  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (r_state)
      c_IDLE: InReady = ~RST;
      c_DONE: begin
        OutValid = 1'b1;
        InReady  = ~RST & OutReady;
      end
      default: ;
    endcase
  end

  mul_csv_seq_digit #(
    .WIDTH   (c_W),
    .DIGIT_W (digitW),
    .POS_W   (c_PW)
  ) u_digit (
    .i_digit      (w_digit),
    .i_y          (r_y),
    .i_pos        (w_pos),
    .i_signed_top (w_signed_top),
    .o_rows       (w_rows)
  );

  AddMopCsv #(
    .WIDTH (c_W),
    .DEPTH (digitW + 3),
    .SPEED (speed)
  ) u_csa (
    .i_rows ({w_rows, r_c, r_s}),
    .o_s    (w_s),
    .o_c    (w_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_tc  <= 1'b0;
      r_s   <= '0;
      r_c   <= '0;
      r_ps  <= '0;
      r_pc  <= '0;
    end else if (w_accept) begin
      r_x   <= Tc ? c_XE'($signed(w_xsum)) : c_XE'(w_xsum);
      r_y   <= Tc ? c_W'($signed(Y)) : c_W'(Y);
      r_tc  <= Tc;
      r_s   <= Acc ? r_ps : '0;
      r_c   <= Acc ? r_pc : '0;
      r_cnt <= '0;
    end else if (r_state == c_BUSY) begin
      r_s <= w_s;
      r_c <= w_c;
      if (w_last) begin
        r_cnt <= '0;
        r_ps  <= w_s;
        r_pc  <= w_c;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign PS = r_ps;
  assign PC = r_pc;

  a_digitw : assert property (@(posedge CLK) (digitW >= 1) && (digitW <= widthX));
  a_widths : assert property (@(posedge CLK) widthX <= widthY);
  a_hold   : assert property (@(posedge CLK) disable iff (RST)
                              $past(OutValid & ~OutReady) |-> ($stable(PS) && $stable(PC)));

endmodule
`default_nettype wire

// File: tb/tb_mul_csv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_csv_seq
// Brief    : Self-checking bench for mul_csv_seq (digitW=2 and digitW=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_csv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_iv = 0, a_ir, a_ov, a_or = 0, a_tc = 0, a_acc = 0;
  logic [7:0] a_xs = 0, a_xc = 0, a_y = 0;
  logic [15:0] a_ps, a_pc;
  logic       b_iv = 0, b_ir, b_ov, b_or = 0, b_tc = 0, b_acc = 0;
  logic [7:0] b_xs = 0, b_xc = 0, b_y = 0;
  logic [15:0] b_ps, b_pc;

  mul_csv_seq #(.widthX(8), .widthY(8), .digitW(2), .speed(lau_pkg::FAST)) u_dut_a (
    .CLK(clk), .RST(rst), .InValid(a_iv), .InReady(a_ir), .XS(a_xs), .XC(a_xc),
    .Y(a_y), .Tc(a_tc), .Acc(a_acc), .OutValid(a_ov), .OutReady(a_or),
    .PS(a_ps), .PC(a_pc));

  mul_csv_seq #(.widthX(8), .widthY(8), .digitW(3), .speed(lau_pkg::SLOW)) u_dut_b (
    .CLK(clk), .RST(rst), .InValid(b_iv), .InReady(b_ir), .XS(b_xs), .XC(b_xc),
    .Y(b_y), .Tc(b_tc), .Acc(b_acc), .OutValid(b_ov), .OutReady(b_or),
    .PS(b_ps), .PC(b_pc));

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] prev_a = '0;
  logic [15:0] prev_b = '0;

  // Product mod 2^16 from plain integer arithmetic on the resolved operands.
  function automatic logic [15:0] ref_prod(input logic [7:0] xs, input logic [7:0] xc,
                                           input logic [7:0] y, input logic tc);
    logic [7:0] x;
    longint     xv, yv;
    x  = xs + xc;
    xv = tc ? longint'($signed(x)) : longint'(x);
    yv = tc ? longint'($signed(y)) : longint'(y);
    return 16'(xv * yv);
  endfunction

  function automatic logic cur_ir(input bit sb);
    return sb ? b_ir : a_ir;
  endfunction
  function automatic logic cur_ov(input bit sb);
    return sb ? b_ov : a_ov;
  endfunction
  function automatic logic [15:0] cur_sum(input bit sb);
    return sb ? 16'(b_ps + b_pc) : 16'(a_ps + a_pc);
  endfunction

  task automatic drive(input bit sb, input logic iv, input logic [7:0] xs,
                       input logic [7:0] xc, input logic [7:0] y,
                       input logic tc, input logic acc);
    if (sb) begin
      b_iv = iv; b_xs = xs; b_xc = xc; b_y = y; b_tc = tc; b_acc = acc;
    end else begin
      a_iv = iv; a_xs = xs; a_xc = xc; a_y = y; a_tc = tc; a_acc = acc;
    end
  endtask

  task automatic set_or(input bit sb, input logic v);
    if (sb) b_or = v; else a_or = v;
  endtask

  // Present an operand set until accepted, then scramble the inputs.
  task automatic issue(input bit sb, input logic [7:0] xs, input logic [7:0] xc,
                       input logic [7:0] y, input logic tc, input logic acc,
                       output bit to);
    drive(sb, 1'b1, xs, xc, y, tc, acc);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cur_ir(sb)) begin
        @(posedge clk); #1;
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    drive(sb, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Edges counted from the accept edge until OutValid is seen.
  task automatic wait_out(input bit sb, output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cur_ov(sb)) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop(input bit sb);
    set_or(sb, 1'b1);
    @(posedge clk); #1;
    set_or(sb, 1'b0);
  endtask

  // Issue one op, check latency and result, pop it and update the model.
  task automatic run_checked(input bit sb, input string tag, input logic [7:0] xs,
                             input logic [7:0] xc, input logic [7:0] y,
                             input logic tc, input logic acc, input int n_lat,
                             input int hold);
    bit to1, to2;
    int lat;
    logic [15:0] exp;
    exp = ref_prod(xs, xc, y, tc) + (acc ? (sb ? prev_b : prev_a) : 16'd0);
    issue(sb, xs, xc, y, tc, acc, to1);
    n_cmp++;
    if (to1 !== 1'b0) begin
      n_err++;
      $display("FAIL %s accept_timeout: got timeout=%0d want 0", tag, to1);
    end
    wait_out(sb, lat, to2);
    n_cmp++;
    if (to2 !== 1'b0 || lat !== n_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d (timeout=%0d) want %0d", tag, lat, to2, n_lat);
    end
    n_cmp++;
    if (cur_sum(sb) !== exp) begin
      n_err++;
      $display("FAIL %s result: got 0x%04h want 0x%04h", tag, cur_sum(sb), exp);
    end
    repeat (hold) begin @(posedge clk); #1; end
    pop(sb);
    if (sb) prev_b = exp; else prev_a = exp;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_ir !== 1'b0) begin n_err++; $display("FAIL reset_inready: got %b want 0", a_ir); end
    n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL reset_outvalid: got %b want 0", a_ov); end
    n_cmp++; if (a_ps !== 16'h0 || a_pc !== 16'h0) begin
      n_err++; $display("FAIL reset_pspc: got %h/%h want 0000/0000", a_ps, a_pc);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
      n_err++; $display("FAIL release_inready: got %b/%b want 1/1", a_ir, b_ir);
    end
    prev_a = '0;
    prev_b = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    run_checked(0, "unsigned_0f_05_13", 8'h0F, 8'h05, 8'd13, 1'b0, 1'b0, 4, 0);
  endtask

  task automatic test_signed;
    run_checked(0, "signed_m2_x3", 8'hFC, 8'h02, 8'h03, 1'b1, 1'b0, 4, 1);
    run_checked(0, "signed_80_80", 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 4, 0);
  endtask

  task automatic test_back_to_back;
    bit to;
    int lat;
    logic [15:0] exp;
    run_checked(0, "acc_first_10x10", 8'd10, 8'd0, 8'd10, 1'b0, 1'b0, 4, 0);
    issue(0, 8'd10, 8'd0, 8'd10, 1'b0, 1'b0, to);
    wait_out(0, lat, to);
    exp = ref_prod(8'd3, 8'd0, 8'd4, 1'b0) + prev_a;
    a_or = 1'b1;
    drive(0, 1'b1, 8'd3, 8'd0, 8'd4, 1'b0, 1'b1);
    #1;
    n_cmp++; if (a_ir !== 1'b1 || a_ov !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: got ir=%b ov=%b want 1/1", a_ir, a_ov);
    end
    @(posedge clk); #1;
    a_or = 1'b0;
    drive(0, 1'b0, 8'hAA, 8'h55, 8'h77, 1'b1, 1'b0);
    n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got ov=%b want 0", a_ov); end
    wait_out(0, lat, to);
    n_cmp++; if (to !== 1'b0 || lat !== 4) begin
      n_err++; $display("FAIL b2b_latency: got %0d (timeout=%0d) want 4", lat, to);
    end
    n_cmp++; if (cur_sum(0) !== exp) begin
      n_err++; $display("FAIL b2b_acc_result: got 0x%04h want 0x%04h", cur_sum(0), exp);
    end
    pop(0);
    prev_a = exp;
  endtask

  task automatic test_backpressure;
    bit to;
    int lat;
    logic [7:0] xs, y;
    logic [15:0] exp1, exp2;
    xs = 8'($urandom); y = 8'($urandom);
    exp1 = ref_prod(xs, 8'd7, y, 1'b0);
    issue(0, xs, 8'd7, y, 1'b0, 1'b0, to);
    wait_out(0, lat, to);
    exp2 = ref_prod(8'd9, 8'd2, 8'd21, 1'b1) + exp1;
    drive(0, 1'b1, 8'd9, 8'd2, 8'd21, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (a_ir !== 1'b0 || a_ov !== 1'b1 || cur_sum(0) !== exp1) begin
        n_err++;
        $display("FAIL stall_%0d: got ir=%b ov=%b sum=0x%04h want 0/1/0x%04h",
                 i, a_ir, a_ov, cur_sum(0), exp1);
      end
      @(posedge clk); #1;
    end
    a_or = 1'b1;
    #1;
    n_cmp++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", a_ir); end
    @(posedge clk); #1;
    a_or = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_out(0, lat, to);
    n_cmp++; if (to !== 1'b0 || lat !== 4) begin
      n_err++; $display("FAIL stall_next_latency: got %0d (timeout=%0d) want 4", lat, to);
    end
    n_cmp++; if (cur_sum(0) !== exp2) begin
      n_err++; $display("FAIL stall_next_result: got 0x%04h want 0x%04h", cur_sum(0), exp2);
    end
    pop(0);
    prev_a = exp2;
  endtask

  task automatic test_reset_midflight;
    bit to;
    issue(0, 8'd100, 8'd50, 8'd77, 1'b0, 1'b0, to);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++; if (a_ov !== 1'b0 || a_ir !== 1'b0) begin
      n_err++; $display("FAIL midreset_flags: got ov=%b ir=%b want 0/0", a_ov, a_ir);
    end
    n_cmp++; if (a_ps !== 16'h0 || a_pc !== 16'h0) begin
      n_err++; $display("FAIL midreset_pspc: got %h/%h want 0000/0000", a_ps, a_pc);
    end
    #1;
    rst = 1'b0;
    prev_a = '0;
    prev_b = '0;
    #1;
    n_cmp++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL midreset_release_ready: got %b want 1", a_ir); end
    @(posedge clk); #1;
    run_checked(0, "post_reset_acc_2x3", 8'd2, 8'd0, 8'd3, 1'b0, 1'b1, 4, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++)
      run_checked(0, $sformatf("rand_a_%0d", k), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 4, int'($urandom_range(0, 2)));
  endtask

  task automatic test_digit3;
    run_checked(1, "d3_255x255", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 3, 0);
    run_checked(1, "d3_wrap_x1", 8'hFF, 8'h02, 8'd5, 1'b0, 1'b0, 3, 0);
    for (int k = 0; k < 12; k++)
      run_checked(1, $sformatf("rand_b_%0d", k), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 3, int'($urandom_range(0, 2)));
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_digit3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
